// File: rtl/spi_ram_wrapper.sv
// rtl/spi_ram_wrapper.sv - SPI slave front-end with a 256x8 single-port RAM
//
// Purpose: memory-mapped SPI peripheral. Each frame is a select bit followed
// by 10 command/data bits (MSB first); read-data frames return one RAM byte
// on miso, MSB first.
//
// Ports:
//   mosi  in   serial data from master, sampled on rising clk
//   miso  out  registered serial data to master, 0 when not transmitting
//   ss_n  in   slave select, active low; high aborts/ends a frame
//   clk   in   system clock, also the SPI bit clock
//   rst_n in   synchronous reset, active HIGH despite the name
module spi_ram_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic mosi,
    output logic miso,
    input  logic ss_n,
    input  logic clk,
    input  logic rst_n
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_rx_cnt;
    logic [9:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rd_flag;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic [7:0]             r_dout;
    logic                   r_tx_valid;
    logic [7:0]             r_tx_shift;
    logic [3:0]             r_tx_cnt;
    logic [7:0]             r_mem [MEM_DEPTH];

    logic w_rx_state;
    logic w_shift_en;
    logic w_last_bit;

    // Bits are taken only while a receive state is active and fewer than 10
    // have arrived; anything after the 10th bit is ignored until ss_n rises.
    assign w_rx_state = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
    assign w_shift_en = w_rx_state && !ss_n && (r_rx_cnt != 4'd10);
    assign w_last_bit = w_shift_en && (r_rx_cnt == 4'd9);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!ss_n) w_next = CHK_CMD;
            CHK_CMD: begin
                if (!mosi)          w_next = WRITE;
                else if (r_rd_flag) w_next = READ_DATA;
                else                w_next = READ_ADD;
            end
            default: w_next = r_state;
        endcase
        if (ss_n) w_next = IDLE;
    end

    // Receive shifter, rx_valid strobe and read-address flag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rx_cnt   <= 4'd0;
            r_rx_data  <= 10'd0;
            r_rx_valid <= 1'b0;
            r_rd_flag  <= 1'b0;
        end else begin
            r_rx_valid <= w_last_bit;
            if (w_shift_en) begin
                r_rx_data <= {r_rx_data[8:0], mosi};
                r_rx_cnt  <= r_rx_cnt + 4'd1;
            end else if (!w_rx_state || ss_n) begin
                r_rx_cnt <= 4'd0;
            end
            if (w_last_bit && (r_state == READ_ADD))  r_rd_flag <= 1'b1;
            if (w_last_bit && (r_state == READ_DATA)) r_rd_flag <= 1'b0;
        end
    end

    // RAM array has no reset so it can map onto a plain memory macro
    always_ff @(posedge clk) begin
        if (!rst_n && r_rx_valid && (r_rx_data[9:8] == 2'b01)) begin
            r_mem[r_wr_addr] <= r_rx_data[7:0];
        end
    end

    // Command decode works on the received bits alone, not on the FSM state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= 8'd0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            if (r_rx_valid) begin
                case (r_rx_data[9:8])
                    2'b00: r_wr_addr <= r_rx_data[ADDR_SIZE-1:0];
                    2'b10: r_rd_addr <= r_rx_data[ADDR_SIZE-1:0];
                    2'b11: begin
                        r_dout     <= r_mem[r_rd_addr];
                        r_tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Transmit: load on tx_valid, then 8 bits MSB first; leaving READ_DATA
    // or raising ss_n drops the transfer and forces miso low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_tx_shift <= 8'd0;
            r_tx_cnt   <= 4'd0;
            miso       <= 1'b0;
        end else if (ss_n || (r_state != READ_DATA)) begin
            r_tx_cnt <= 4'd0;
            miso     <= 1'b0;
        end else if (r_tx_valid) begin
            r_tx_shift <= r_dout;
            r_tx_cnt   <= 4'd8;
            miso       <= 1'b0;
        end else if (r_tx_cnt != 4'd0) begin
            miso       <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_tx_cnt   <= r_tx_cnt - 4'd1;
        end else begin
            miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// tb/tb_spi_ram_wrapper.sv - self-checking bench for spi_ram_wrapper
module tb_spi_ram_wrapper;

    logic mosi;
    logic miso;
    logic ss_n;
    logic clk;
    logic rst_n;

    spi_ram_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .mosi  (mosi),
        .miso  (miso),
        .ss_n  (ss_n),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory image plus the slave's architectural registers
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    logic [7:0] m_wa;
    logic [7:0] m_ra;
    bit         m_flag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wa   = 8'd0;
        m_ra   = 8'd0;
        m_flag = 1'b0;
    endtask

    // Applies a completed frame to the model; reports whether a byte goes out
    task automatic model_frame(input logic sel, input logic [9:0] bits,
                               output bit tx, output bit known, output logic [7:0] byte_o);
        bit is_rd_data;
        is_rd_data = sel && m_flag;
        tx     = 1'b0;
        known  = 1'b1;
        byte_o = 8'd0;
        case (bits[9:8])
            2'b00: m_wa = bits[7:0];
            2'b01: begin m_mem[m_wa] = bits[7:0]; m_known[m_wa] = 1'b1; end
            2'b10: m_ra = bits[7:0];
            default: begin
                if (is_rd_data) begin
                    tx     = 1'b1;
                    known  = m_known[m_ra];
                    byte_o = m_mem[m_ra];
                end
            end
        endcase
        if (sel) m_flag = !m_flag;
    endtask

    // Drives one frame: nbits data bits (10 = complete), then nhold more
    // cycles with ss_n low, capturing miso during the transmit window.
    task automatic drive_frame(input logic sel, input logic [9:0] bits, input int nbits,
                               input int nhold, output logic [7:0] got, output int ngot);
        got  = 8'd0;
        ngot = 0;
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = sel;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); mosi = bits[9-i];
        end
        for (int k = 0; k < nhold; k++) begin
            @(negedge clk); mosi = 1'($urandom);
            @(posedge clk); #1;
            if (k >= 2 && k < 10) begin
                got[9-k] = miso;
                ngot++;
            end
        end
        @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
        @(posedge clk); #1;
        check_eq("miso_after_ss", 32'(miso), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic sel, input logic [9:0] bits,
                             input int nbits, input int nhold);
        bit tx, known;
        logic [7:0] exp_b, got, mask;
        int ngot;
        tx = 1'b0; known = 1'b1; exp_b = 8'd0;
        if (nbits == 10) model_frame(sel, bits, tx, known, exp_b);
        drive_frame(sel, bits, nbits, nhold, got, ngot);
        mask = 8'hFF << (8 - ngot);
        if (ngot == 0) mask = 8'h00;
        if (ngot > 0 && (!tx || known))
            check_eq(tag, 32'(got & mask), 32'(tx ? (exp_b & mask) : 8'h00));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check_eq("miso_in_reset", 32'(miso), 32'd0);
        end
        @(negedge clk); rst_n = 1'b0; ss_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] g;
        int         ng;
        for (int i = 0; i < 256; i++) begin m_known[i] = 1'b0; m_mem[i] = 8'd0; end
        model_reset();
        rst_n = 1'b1; ss_n = 1'b0; mosi = 1'b0;
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("miso_idle", 32'(miso), 32'd0);
        end

        // Directed sequence
        run_frame("wr_addr_ff",  1'b0, 10'b00_1111_1111, 10, 0);
        run_frame("wr_data_ff",  1'b0, 10'b01_1111_1111, 10, 0);
        run_frame("wr_addr_f0",  1'b0, 10'b00_1111_0000, 10, 0);
        run_frame("wr_data_f0",  1'b0, 10'b01_0000_0001, 10, 0);
        run_frame("rd_addr_f0",  1'b1, 10'b10_1111_0000, 10, 4);
        run_frame("rd_data_f0",  1'b1, 10'b11_0101_1010, 10, 10);
        check_eq("flag_cleared", 32'(m_flag), 32'd0);
        run_frame("rd_addr_ff",  1'b1, 10'b10_1111_1111, 10, 0);
        run_frame("rd_data_ff",  1'b1, 10'b11_0000_0000, 10, 12);

        // Aborted write-data frame leaves mem[0xF0] alone
        run_frame("wr_addr_f0b", 1'b0, 10'b00_1111_0000, 10, 0);
        run_frame("abort_wr",    1'b0, 10'b01_1010_1010, 5, 0);
        run_frame("rd_addr_ab",  1'b1, 10'b10_1111_0000, 10, 0);
        run_frame("rd_data_ab",  1'b1, 10'b11_0000_0000, 10, 10);

        // Abort during transmit: first 3 bits, then miso must drop
        run_frame("rd_addr_tx",  1'b1, 10'b10_1111_1111, 10, 0);
        run_frame("tx_abort",    1'b1, 10'b11_0000_0000, 10, 5);

        // Reset in the middle of a frame loses it and clears addresses/flag
        run_frame("rd_addr_pre", 1'b1, 10'b10_1111_1111, 10, 0);
        @(negedge clk); ss_n = 1'b0;
        @(negedge clk); mosi = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); mosi = 1'b1; end
        do_reset(2);
        run_frame("rd_after_rst_a", 1'b1, 10'b10_1111_0000, 10, 0);
        run_frame("rd_after_rst_d", 1'b1, 10'b11_0000_0000, 10, 10);

        // Randomized traffic over a small address pool to get frequent hits
        for (int n = 0; n < 160; n++) begin
            logic       sel;
            logic [1:0] cmd;
            logic [7:0] addr;
            int         nbits, nhold;
            sel   = 1'($urandom);
            cmd   = 2'($urandom);
            addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255));
            nbits = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10;
            nhold = (nbits == 10) ? (($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 10) : 0;
            run_frame("rand", sel, {cmd, addr}, nbits, nhold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/spi_ram_wrapper.md
Name: spi_ram_wrapper

Overview:
SPI slave front-end combined with a 256x8 single-port RAM in one block. An external SPI master sends 11-bit frames on mosi while ss_n is low. Each frame carries one command: write address, write data, read address or read data. For read-data frames the RAM byte is shifted back on miso, MSB first. Used as a memory-mapped SPI peripheral.

Parameters:
MEM_DEPTH, 256, number of RAM words
ADDR_SIZE, 8, RAM address width (log2 MEM_DEPTH)

Ports:
clk  input  1  system clock; all logic on rising edge (also the SPI bit clock)
rst_n  input  1  synchronous, active-high reset: asserted when 1, sampled on rising clk
mosi  input  1  serial data from master, sampled on rising clk
miso  output  1  serial data to master, registered
ss_n  input  1  slave select, active low; high aborts/ends a frame
Positional declaration order is fixed: mosi, miso, ss_n, clk, rst_n.

Behaviour:
- Reset (rst_n==1 at a rising edge):
  - FSM to IDLE; miso=0; shift counters=0; rx_valid=0; tx_valid=0.
  - Write address, read address and RAM dout all cleared to 0; read-address-received flag cleared.
  - RAM array contents are not cleared.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - Any state with ss_n==1 -> IDLE on the next edge. A partially received frame is discarded and no rx_valid is issued.
  - IDLE, ss_n==0 -> CHK_CMD.
  - CHK_CMD samples mosi (select bit):
    - 0 -> WRITE.
    - 1 with flag==0 -> READ_ADD.
    - 1 with flag==1 -> READ_DATA.
- Receive (WRITE, READ_ADD, READ_DATA):
  - 10 consecutive mosi bits are shifted into rx_data[9:0], MSB first.
  - On the edge sampling the 10th bit, rx_valid pulses high for exactly one cycle with rx_data complete.
  - Further mosi bits are ignored until ss_n returns high.
- RAM, on rx_valid, decodes rx_data[9:8]; the decode is independent of the FSM state:
  - 00: write address <= rx_data[7:0].
  - 01: mem[write address] <= rx_data[7:0].
  - 10: read address <= rx_data[7:0].
  - 11: dout <= mem[read address]; tx_valid pulses for 1 cycle.
  - Latency: rx_valid -> memory update or dout/tx_valid = 1 cycle.
- Read-address flag:
  - Set when a READ_ADD frame completes (rx_valid).
  - Cleared when a READ_DATA frame completes.
  - Successive read-select frames therefore alternate READ_ADD, READ_DATA, READ_ADD, ...
- Transmit (READ_DATA only):
  - On tx_valid, dout is loaded into the tx shift register.
  - Starting the next edge, miso outputs dout[7] down to dout[0], one bit per cycle over 8 cycles.
  - miso then returns to 0 and the FSM stays in READ_DATA until ss_n goes high.
  - Master must keep ss_n low at least 1+1+10+2+8 cycles for a full read.
  - miso is 0 whenever not transmitting.
- Boundaries:
  - Addresses are 8-bit, no wrap logic needed; 0xFF is a valid location.
  - Reset mid-frame: state returns to IDLE and the frame is lost.
  - ss_n high during tx: transmission is aborted and miso goes to 0.
  - A write to the same address as a pending read is ordered by frame sequence only.

Test Plan:
- Reset: rst_n=1 for 2 cycles with ss_n=0 -> miso=0, FSM IDLE, no rx_valid; then release and hold ss_n high -> miso stays 0.
- Write address: ss_n=0, select 0, bits 00_1111_1111 -> write address=0xFF. Then write data: select 0, bits 01_1111_1111 -> mem[0xFF]=0xFF.
- Second location: write address 00_1111_0000 (0xF0), then write data 01_0000_0001 -> mem[0xF0]=0x01.
- Read-back: read-address frame 10_1111_0000, then read-data frame 11_xxxx_xxxx with ss_n held low ≥8 extra cycles -> miso serial 0,0,0,0,0,0,0,1. Then read address 0xFF plus read data -> miso 1,1,1,1,1,1,1,1.
- Abort: ss_n high after 5 bits of a write-data frame -> no memory change. A subsequent read of that address returns the old value.
- Flag alternation: two consecutive read-select frames -> first is treated as READ_ADD and latches the address; second is READ_DATA and transmits the byte.
